// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants (clk-cycle horizontal units, line vertical units)
// and the registered output bundle of the sync generator.
package vga_timing_pkg;

    localparam int H_SYNC     = 384;
    localparam int H_BP       = 192;
    localparam int H_DISP     = 2560;
    localparam int H_TOTAL    = 3200;
    localparam int CLK_PER_PX = 4;

    localparam int V_SYNC  = 2;
    localparam int V_BP    = 29;
    localparam int V_DISP  = 480;
    localparam int V_TOTAL = 521;

    localparam int H_W  = 12;
    localparam int V_W  = 10;
    localparam int PX_W = 10;

    localparam int H_VIS_START = H_SYNC + H_BP;
    localparam int H_VIS_END   = H_VIS_START + H_DISP;
    localparam int V_VIS_START = V_SYNC + V_BP;
    localparam int V_VIS_END   = V_VIS_START + V_DISP;
    localparam int PX_SHIFT    = $clog2(CLK_PER_PX);

    typedef struct packed {
        logic            hsync;
        logic            vsync;
        logic            display_en;
        logic [PX_W-1:0] pixel_x;
        logic [PX_W-1:0] pixel_y;
        logic            frame_start;
    } sync_out_t;

endpackage

// File: rtl/vga_sync_timing_if.sv
// Bundle between the horizontal counter / display path (master) and the sync generator (slave).
interface vga_sync_timing_if;
    import vga_timing_pkg::*;

    logic [H_W-1:0]  h_count;
    logic            line_end;
    logic            hsync;
    logic            vsync;
    logic            display_en;
    logic [PX_W-1:0] pixel_x;
    logic [PX_W-1:0] pixel_y;
    logic [V_W-1:0]  v_count;
    logic            frame_start;

    modport master (
        output h_count, line_end,
        input  hsync, vsync, display_en, pixel_x, pixel_y, v_count, frame_start
    );

    modport slave (
        input  h_count, line_end,
        output hsync, vsync, display_en, pixel_x, pixel_y, v_count, frame_start
    );

endinterface

// File: rtl/vga_v_counter.sv
// Vertical line counter, advanced by the upstream end-of-line strobe; frame_wrap is high
// while the counter sits on line 0.
module vga_v_counter
    import vga_timing_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           line_end,
    output logic [V_W-1:0] v_count,
    output logic           frame_wrap
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_count <= '0;
        end else if (line_end) begin
            v_count <= (v_count == V_W'(V_TOTAL - 1)) ? '0 : v_count + 1'b1;
        end
    end

    assign frame_wrap = (v_count == '0);

endmodule

// File: rtl/vga_sync_timing.sv
// Decodes (h_count, v_count) into registered sync, enable, coordinates and frame-start,
// one clk behind the inputs.
module vga_sync_timing
    import vga_timing_pkg::*;
(
    input logic          clk,
    input logic          reset,
    vga_sync_timing_if.slave bus
);

    logic [V_W-1:0] v_count;
    logic           on_line0;
    logic           h_legal;
    logic           h_vis;
    logic           v_vis;
    sync_out_t      nxt;
    sync_out_t      out_q;

    vga_v_counter u_v_counter (
        .clk        (clk),
        .reset      (reset),
        .line_end   (bus.line_end),
        .v_count    (v_count),
        .frame_wrap (on_line0)
    );

    always_comb begin
        nxt     = '0;
        h_legal = (bus.h_count < H_W'(H_TOTAL));
        h_vis   = h_legal
                  && (bus.h_count >= H_W'(H_VIS_START))
                  && (bus.h_count <  H_W'(H_VIS_END));
        v_vis   = (v_count >= V_W'(V_VIS_START)) && (v_count < V_W'(V_VIS_END));

        // An out-of-range h_count lands above H_SYNC, so hsync idles high for it.
        nxt.hsync       = !(bus.h_count < H_W'(H_SYNC));
        nxt.vsync       = !(v_count < V_W'(V_SYNC));
        nxt.display_en  = h_vis && v_vis;
        nxt.frame_start = on_line0 && (bus.h_count == '0);
        if (h_vis && v_vis) begin
            nxt.pixel_x = PX_W'((bus.h_count - H_W'(H_VIS_START)) >> PX_SHIFT);
            nxt.pixel_y = v_count - V_W'(V_VIS_START);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q             <= '0;
            out_q.hsync       <= 1'b1;
            out_q.vsync       <= 1'b1;
        end else begin
            out_q <= nxt;
        end
    end

    assign bus.hsync       = out_q.hsync;
    assign bus.vsync       = out_q.vsync;
    assign bus.display_en  = out_q.display_en;
    assign bus.pixel_x     = out_q.pixel_x;
    assign bus.pixel_y     = out_q.pixel_y;
    assign bus.frame_start = out_q.frame_start;
    assign bus.v_count     = v_count;

endmodule
